pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...).
//  Carries a DATA_W payload with valid/ready handshake, stall and flush.
//  A 2-entry skid buffer gives full throughput with a registered in_ready_o,
//  so there is no combinational ready path. Saturating stall counter for perf.
// PARAMETERS
//  DATA_W     64      payload width (e.g. {pc[31:0], inst[31:0]})
//  FLUSH_VAL  0       value loaded into all payload regs on reset/flush (DATA_W wide)
//  CNT_W      16      width of stall_cnt_o
// PORTS
//  clk_i        in   1        clock, all state updates on posedge
//  rst_n_i      in   1        synchronous reset, active-low
//  flush_i      in   1        discard all held entries (bubble)
//  stall_i      in   1        hold output entry; blocks drain regardless of out_ready_i
//  in_valid_i   in   1        upstream payload valid
//  in_ready_o   out  1        stage can accept (registered)
//  in_data_i    in   DATA_W   upstream payload
//  out_valid_o  out  1        out_data_o valid
//  out_ready_i  in   1        downstream accepts
//  out_data_o   out  DATA_W   payload to next stage (main reg)
//  occupancy_o  out  2        entries held: 0, 1 or 2
//  stall_cnt_o  out  CNT_W    cycles with out_valid_o=1 and no drain, saturating
// BEHAVIOUR
//  accept = in_valid_i & in_ready_o;  drain = out_valid_o & out_ready_i & ~stall_i
//  States: EMPTY(occ 0, out_valid 0), MAIN(occ 1, out_valid 1), FULL(occ 2, out_valid 1)
//  in_ready_o registered: next = (next_state != FULL); 0 during reset
//  Transitions (no flush):
//   EMPTY: accept -> MAIN, main<=in_data_i; else stay
//   MAIN : accept&drain -> MAIN, main<=in_data_i; accept&~drain -> FULL, skid<=in_data_i
//          ~accept&drain -> EMPTY; else hold
//   FULL : drain -> MAIN, main<=skid; else hold (accept impossible, in_ready_o=0)
//  Order preserved: skid entry always older than any later accept
//  Latency: accept at edge N into EMPTY -> out_valid_o/out_data_o at edge N
//  Data held stable while out_valid_o=1 and no drain (stall or ~out_ready_i)
//  flush_i (priority below reset, above all else): next state EMPTY,
//   main/skid <= FLUSH_VAL, in_ready_o <= 1; input offered in the flush cycle is
//   dropped; an output drain in the flush cycle counts as completed
//  Reset (rst_n_i=0 at edge): state EMPTY, out_valid_o=0, out_data_o=FLUSH_VAL,
//   occupancy_o=0, in_ready_o=0, stall_cnt_o=0; first edge after release sets in_ready_o=1
//  Reset mid-operation discards all entries; no partial transfer
//  stall_cnt_o: +1 each edge where out_valid_o & ~drain; holds at 2^CNT_W-1;
//   cleared only by reset (flush does not clear)
//  out_valid_o, occupancy_o decoded from state register (glitch-free)
// TESTING
//  1 reset: rst_n_i=0 2 cycles -> out_valid_o=0, out_data_o=0, in_ready_o=0; release ->
//    in_ready_o=1 after 1 edge
//  2 streaming: in_valid_i=1 data 1..8, out_ready_i=1 -> out 1..8 one per cycle, occ<=1,
//    in_ready_o never drops
//  3 backpressure: MAIN with A, out_ready_i=0, offer B -> occ=2, in_ready_o=0 next cycle,
//    out_data_o=A held; out_ready_i=1 -> A then B, in order, none lost/duplicated
//  4 stall: occ=1, stall_i=1 for 3 cycles with out_ready_i=1 -> no drain,
//    stall_cnt_o +3; data held
//  5 flush: occ=2 (A,B), flush_i=1 with in_valid_i=1 data C -> next cycle occ=0,
//    out_valid_o=0, C dropped, in_ready_o=1
//  6 saturation: CNT_W=4, 20 blocked cycles -> stall_cnt_o=15; random valid/ready
//    scoreboard 10k cycles -> in-order, lossless

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, registered upstream ready,
// stall/flush control and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_p0;
    state_t             state_nxt;
    logic [DATA_W-1:0]  main_p0;
    logic [DATA_W-1:0]  main_nxt;
    logic [DATA_W-1:0]  skid_p0;
    logic [DATA_W-1:0]  skid_nxt;
    logic               ready_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               accept;
    logic               drain;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign accept = in_valid_i & ready_p0;
    assign drain  = out_valid_o & out_ready_i & ~stall_i;

    always_comb begin
        state_nxt = state_p0;
        main_nxt  = main_p0;
        skid_nxt  = skid_p0;
        if (flush_i) begin
            state_nxt = EMPTY;
            main_nxt  = FLUSH_VAL;
            skid_nxt  = FLUSH_VAL;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = MAIN;
                        main_nxt  = in_data_i;
                    end
                end
                MAIN: begin
                    if (accept && drain) begin
                        main_nxt = in_data_i;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data_i;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is always older than anything accepted later.
                    if (drain) begin
                        state_nxt = MAIN;
                        main_nxt  = skid_p0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Stage register boundary
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_p0 <= EMPTY;
            ready_p0 <= 1'b0;
            main_p0  <= FLUSH_VAL;
            skid_p0  <= FLUSH_VAL;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            ready_p0 <= (state_nxt != FULL);
            main_p0  <= main_nxt;
            skid_p0  <= skid_nxt;
            if (out_valid_o && !drain) begin
                cnt_p0 <= sat_inc(cnt_p0);
            end
        end
    end

    always_comb begin
        occupancy_o = 2'd0;
        case (state_p0)
            MAIN:    occupancy_o = 2'd1;
            FULL:    occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    assign out_valid_o = (state_p0 != EMPTY);
    assign out_data_o  = main_p0;
    assign in_ready_o  = ready_p0;
    assign stall_cnt_o = cnt_p0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table plus reset/saturation sequences and a randomized
// in-order scoreboard for pipe_stage_skid.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occ;
    logic [15:0] cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .FLUSH_VAL(32'h0), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occ), .stall_cnt_o(cnt)
    );

    pipe_stage_skid #(.DATA_W(32), .FLUSH_VAL(32'h0), .CNT_W(4)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_data_i(in_data),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
        .occupancy_o(s_occ), .stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic        fl;
        logic        st;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        er;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic st, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic ev, input logic [31:0] ed,
                       input logic [1:0] eo, input logic er, input logic [15:0] ec);
        vec_t v;
        v.fl = fl; v.st = st; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.eo = eo; v.er = er; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] seq;
    bit          acc, drn;

    initial begin
        // Reset held two cycles
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_occ", occ, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        step();
        chk("rel_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);

        // Streaming 1..8, drain, backpressure, stall, flush, flush-with-drain
        add(0,0,1,32'd1,1, 1,32'd1,1,1,0);
        for (int k = 2; k <= 8; k++) add(0,0,1,k,1, 1,k,1,1,0);
        add(0,0,0,32'd0,1,   0,32'd8,0,1,0);
        add(0,0,1,32'hA,0,   1,32'hA,1,1,0);
        add(0,0,1,32'hB,0,   1,32'hA,2,0,1);
        add(0,0,0,32'd0,0,   1,32'hA,2,0,2);
        add(0,0,0,32'd0,1,   1,32'hB,1,1,2);
        add(0,0,0,32'd0,1,   0,32'hB,0,1,2);
        add(0,0,1,32'h11,1,  1,32'h11,1,1,2);
        add(0,1,0,32'd0,1,   1,32'h11,1,1,3);
        add(0,1,0,32'd0,1,   1,32'h11,1,1,4);
        add(0,1,0,32'd0,1,   1,32'h11,1,1,5);
        add(0,0,0,32'd0,1,   0,32'h11,0,1,5);
        add(0,0,1,32'hA1,0,  1,32'hA1,1,1,5);
        add(0,0,1,32'hB2,0,  1,32'hA1,2,0,6);
        add(1,0,1,32'hC3,0,  0,32'h0,0,1,7);
        add(0,0,0,32'd0,1,   0,32'h0,0,1,7);
        add(0,0,1,32'hD4,1,  1,32'hD4,1,1,7);
        add(0,0,0,32'd0,1,   0,32'hD4,0,1,7);
        add(0,0,1,32'hE5,1,  1,32'hE5,1,1,7);
        add(0,1,1,32'hF6,1,  1,32'hE5,2,0,8);
        add(0,0,0,32'd0,1,   1,32'hF6,1,1,8);
        add(1,0,0,32'd0,1,   0,32'h0,0,1,8);

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].fl; stall = vecs[i].st; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
            chk($sformatf("v%0d_occ", i), occ, vecs[i].eo);
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].er);
            chk($sformatf("v%0d_cnt", i), cnt, vecs[i].ec);
        end

        // Reset mid-operation discards the held entry
        idle_inputs();
        in_valid = 1'b1; in_data = 32'h77;
        step();
        chk("mid_occ_pre", occ, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_cnt", cnt, 0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rel_ready", in_ready, 1);

        // Saturation: one entry blocked for 20 cycles
        in_valid = 1'b1; in_data = 32'h55;
        step();
        idle_inputs();
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt4", s_cnt, 15);
        chk("sat_cnt16", cnt, 20);
        chk("sat_data", out_data, 32'h55);
        chk("sat_valid", out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_keeps_cnt", cnt, 21);
        chk("flush_keeps_cnt4", s_cnt, 15);

        // Random valid/ready/stall scoreboard
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        seq = 32'h100;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 7) == 0);
            in_data   = seq;
            #0;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready && !stall;
            if (drn) begin
                if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
                else chk("rnd_data", out_data, q.pop_front());
            end
            if (acc) begin
                q.push_back(seq);
                seq++;
            end
            step();
            chk("rnd_occ", occ, q.size());
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int c = 0; c < 4 && q.size() > 0; c++) begin
            if (out_valid) chk("tail_data", out_data, q.pop_front());
            step();
        end
        chk("tail_empty", q.size(), 0);
        chk("tail_occ", occ, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
